ttl_down_counter_chain: RTL and testbench

- Synchronous binary down-counter built from STAGES cascaded 4-bit down-counting stages. Each stage behaves like a 74169 in down mode.
- Counts down the value that the board's up-counters count up. Used for programmable dividers and timers in the video and sound timing chains.
- Provides parallel load, asynchronous clear, and a look-ahead borrow chain.
- Optional auto-reload mode re-arms the counter without glue logic. A registered terminal-count pulse gives one clean event per expiry.

---
 rtl/ttl_down_counter_chain_pkg.sv | 8 +
 rtl/ttl_74169_down_stage.sv | 29 ++
 rtl/ttl_down_counter_chain.sv | 74 +++++++
 tb/tb_ttl_down_counter_chain.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ttl_down_counter_chain_pkg.sv
// Shared constants for the TTL counter models: stage width and nibble end values.
package ttl_down_counter_chain_pkg;

    localparam int unsigned StageWidth = 4;
    localparam logic [StageWidth-1:0] NibbleZero = 4'h0;
    localparam logic [StageWidth-1:0] NibbleOnes = 4'hF;

endpackage

// File: rtl/ttl_74169_down_stage.sv
// One 74169-style 4-bit stage in down mode: synchronous load, enabled decrement, async clear.
module ttl_74169_down_stage
    import ttl_down_counter_chain_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Clear_bar,
    input  logic                  Load_bar,
    input  logic                  EN,
    input  logic [StageWidth-1:0] D,
    output logic [StageWidth-1:0] Q,
    output logic                  BZ
);

    logic [StageWidth-1:0] q_q;

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            q_q <= NibbleZero;
        end else if (!Load_bar) begin
            q_q <= D;
        end else if (EN) begin
            q_q <= (q_q == NibbleZero) ? NibbleOnes : q_q - 4'd1;
        end
    end

    assign Q  = q_q;
    assign BZ = (q_q == NibbleZero);

endmodule

// File: rtl/ttl_down_counter_chain.sv
// Cascaded 74169-style down-counter with look-ahead borrow, optional auto-reload and a
// registered terminal-count pulse.
module ttl_down_counter_chain
    import ttl_down_counter_chain_pkg::*;
#(
    parameter int unsigned STAGES     = 2,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned RELOAD     = 0,
    parameter int unsigned DELAY_RISE = 0,
    parameter int unsigned DELAY_FALL = 0
) (
    input  logic                    Clk,
    input  logic                    Clear_bar,
    input  logic                    Load_bar,
    input  logic                    ENT,
    input  logic                    ENP,
    input  logic [WIDTH*STAGES-1:0] D,
    output logic [WIDTH*STAGES-1:0] Q,
    output logic                    BO,
    output logic                    TC
);

    logic [STAGES-1:0]       en_chain;
    logic [STAGES-1:0]       bz;
    logic [WIDTH*STAGES-1:0] q_int;
    logic                    count_en;
    logic                    q_zero;
    logic                    reload_hit;
    logic                    stage_load_bar;
    logic                    tc_q;

    assign count_en = ENT & ENP;
    assign q_zero   = &bz;

    // An enabled count at zero in reload mode is folded into the stages' parallel load.
    assign reload_hit     = (RELOAD != 0) && count_en && q_zero;
    assign stage_load_bar = Load_bar & ~reload_hit;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        if (k == 0) begin : gen_first
            assign en_chain[k] = count_en;
        end else begin : gen_next
            assign en_chain[k] = en_chain[k-1] & bz[k-1];
        end

        ttl_74169_down_stage u_stage (
            .Clk      (Clk),
            .Clear_bar(Clear_bar),
            .Load_bar (stage_load_bar),
            .EN       (en_chain[k]),
            .D        (D[k*WIDTH +: WIDTH]),
            .Q        (q_int[k*WIDTH +: WIDTH]),
            .BZ       (bz[k])
        );
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= Load_bar & count_en & q_zero;
        end
    end

    // Output delays are zero-time in this synthesizable model; the parameters stay for
    // interface compatibility with the other TTL models.
    logic unused_delay;
    assign unused_delay = ^{DELAY_RISE, DELAY_FALL};

    assign Q  = q_int;
    assign BO = ENT & q_zero;
    assign TC = tc_q;

endmodule

// File: tb/tb_ttl_down_counter_chain.sv
// Randomized bench for ttl_down_counter_chain with an arithmetic reference model.
module tb_ttl_down_counter_chain;

    logic        Clk = 1'b0;
    logic        Clear_bar;
    logic        Load_bar;
    logic        ENT;
    logic        ENP;
    logic [7:0]  D8;
    logic [11:0] D12;

    logic [7:0]  q_a, q_r;
    logic [11:0] q_c;
    logic        bo_a, bo_r, bo_c;
    logic        tc_a, tc_r, tc_c;

    // Reference state: plain modular arithmetic on whole counter values.
    logic [7:0]  m_a, m_r;
    logic [11:0] m_c;
    logic        t_a, t_r, t_c;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    int pulses;

    always #5 Clk = ~Clk;

    ttl_down_counter_chain #(.STAGES(2), .RELOAD(0)) u_dut_a (
        .Clk(Clk), .Clear_bar(Clear_bar), .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP),
        .D(D8), .Q(q_a), .BO(bo_a), .TC(tc_a)
    );

    ttl_down_counter_chain #(.STAGES(2), .RELOAD(1)) u_dut_r (
        .Clk(Clk), .Clear_bar(Clear_bar), .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP),
        .D(D8), .Q(q_r), .BO(bo_r), .TC(tc_r)
    );

    ttl_down_counter_chain #(.STAGES(3), .RELOAD(0)) u_dut_c (
        .Clk(Clk), .Clear_bar(Clear_bar), .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP),
        .D(D12), .Q(q_c), .BO(bo_c), .TC(tc_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            m_a <= '0; m_r <= '0; m_c <= '0;
            t_a <= 1'b0; t_r <= 1'b0; t_c <= 1'b0;
        end else if (!Load_bar) begin
            m_a <= D8; m_r <= D8; m_c <= D12;
            t_a <= 1'b0; t_r <= 1'b0; t_c <= 1'b0;
        end else if (ENT && ENP) begin
            m_a <= m_a - 8'd1;
            m_r <= (m_r == 8'd0) ? D8 : m_r - 8'd1;
            m_c <= m_c - 12'd1;
            t_a <= (m_a == 8'd0);
            t_r <= (m_r == 8'd0);
            t_c <= (m_c == 12'd0);
        end else begin
            t_a <= 1'b0; t_r <= 1'b0; t_c <= 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("a_q",  q_a,  m_a);
            chk("a_bo", bo_a, ENT && (m_a == 8'd0));
            chk("a_tc", tc_a, t_a);
            chk("r_q",  q_r,  m_r);
            chk("r_bo", bo_r, ENT && (m_r == 8'd0));
            chk("r_tc", tc_r, t_r);
            chk("c_q",  q_c,  m_c);
            chk("c_bo", bo_c, ENT && (m_c == 12'd0));
            chk("c_tc", tc_c, t_c);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clear_bar = 1'b0; Load_bar = 1'b1; ENT = 1'b0; ENP = 1'b0; D8 = '0; D12 = '0;
        #3;
        chk("rst_q", q_a, 8'h00);
        chk("rst_tc", tc_a, 1'b0);
        step();
        step();
        Clear_bar = 1'b1;
        cmp_en = 1'b1;

        // Load 03 and count through the underflow.
        Load_bar = 1'b0; D8 = 8'h03;
        step(); chk("t1_load", q_a, 8'h03);
        Load_bar = 1'b1; ENT = 1'b1; ENP = 1'b1;
        step(); chk("t1_q02", q_a, 8'h02);
        step(); chk("t1_q01", q_a, 8'h01);
        step(); chk("t1_q00", q_a, 8'h00); chk("t1_bo00", bo_a, 1'b1); chk("t1_tc0", tc_a, 1'b0);
        step(); chk("t1_qff", q_a, 8'hFF); chk("t1_tc1", tc_a, 1'b1); chk("t1_boff", bo_a, 1'b0);
        step(); chk("t1_qfe", q_a, 8'hFE); chk("t1_tcoff", tc_a, 1'b0);

        // Auto-reload from 10.
        Load_bar = 1'b0; D8 = 8'h10;
        step(); chk("t2_load", q_r, 8'h10);
        Load_bar = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (tc_r) pulses++;
            if (i == 1) chk("t2_borrow", q_r, 8'h0F);
        end
        chk("t2_reload", q_r, 8'h10);
        chk("t2_tc", tc_r, 1'b1);
        chk("t2_pulses", pulses, 1);

        // Borrow out at zero with and without ENT.
        Load_bar = 1'b0; D8 = 8'h00; ENT = 1'b0; ENP = 1'b0;
        step();
        Load_bar = 1'b1; ENT = 1'b1;
        #1 chk("t3_bo_ent", bo_a, 1'b1);
        step(); chk("t3_hold", q_a, 8'h00); chk("t3_tc", tc_a, 1'b0); chk("t3_bo", bo_a, 1'b1);
        ENT = 1'b0;
        #1 chk("t3_bo_off", bo_a, 1'b0);
        step(); chk("t3_tc2", tc_a, 1'b0);

        // Load beats count at zero.
        Load_bar = 1'b0; ENT = 1'b1; ENP = 1'b1; D8 = 8'h5A;
        step(); chk("t4_q", q_a, 8'h5A); chk("t4_tc", tc_a, 1'b0);

        // Asynchronous clear mid-count.
        D8 = 8'h02;
        step();
        Load_bar = 1'b1;
        #1 Clear_bar = 1'b0;
        #1 chk("t5_q", q_a, 8'h00); chk("t5_tc", tc_a, 1'b0); chk("t5_qc", q_c, 12'h000);
        Clear_bar = 1'b1;
        step(); chk("t5_wrap", q_a, 8'hFF); chk("t5_wrap_tc", tc_a, 1'b1);

        // Look-ahead borrow across two stages.
        ENT = 1'b0; Load_bar = 1'b0; D12 = 12'h100;
        step(); chk("t6_load", q_c, 12'h100);
        Load_bar = 1'b1; ENT = 1'b1; ENP = 1'b1;
        step(); chk("t6_borrow", q_c, 12'h0FF);
        ENT = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            step();
            Load_bar = ($urandom_range(0, 9) != 0);
            D8  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            D12 = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 3)) : 12'($urandom);
            ENT = ($urandom_range(0, 7) != 0);
            ENP = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #1 Clear_bar = 1'b0;
                #1 Clear_bar = 1'b1;
            end
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
